simple_dma_master: RTL and testbench
====================================

SIMPLE_DMA_MASTER -- requirements
Module: simple_dma_master

Interface
REQ-001 Parameter BASE_ADDR, default 15'h0110, peripheral register base address, aligned to 2^DEC_WD.
REQ-002 Parameter DEC_WD, default 3, number of address bits decoded locally.
REQ-003 mclk  in  1  main system clock; all state changes on its rising edge.
REQ-004 puc_rst  in  1  main system reset, asynchronous, active-high.
REQ-005 per_addr  in  14  peripheral word address.
REQ-006 per_din  in  16  peripheral write data.
REQ-007 per_en  in  1  peripheral enable.
REQ-008 per_we  in  2  peripheral byte write enables.
REQ-009 per_dout  out  16  peripheral read data; 0 when this block is not selected.
REQ-010 dma_addr  out  15  DMA word address [15:1].
REQ-011 dma_din  out  16  DMA write data.
REQ-012 dma_en  out  1  DMA access request.
REQ-013 dma_we  out  2  DMA byte write enables; 00 means read.
REQ-014 dma_priority  out  1  DMA priority request; mirrors CTRL.PRIO.
REQ-015 dma_dout  in  16  DMA read data.
REQ-016 dma_ready  in  1  access accepted this cycle.
REQ-017 dma_resp  in  1  error response; valid only when dma_ready=1.
REQ-018 irq_dma  out  1  interrupt request.

Function
REQ-019 Registers at word offsets: 0x0 SRC, 0x2 DST, 0x4 CNT (word count), 0x6 CTRL. Any per_we!=0 is a full 16-bit write; a read is per_we=0.
REQ-020 SRC and DST bit 0 always reads 0; writes to SRC, DST and CNT are ignored while BUSY=1.
REQ-021 CTRL bit assignments:
- [0] START: write-1 pulse, reads 0.
- [1] BUSY: read-only.
- [2] DONE: write-1-to-clear.
- [3] ERR: write-1-to-clear.
- [4] IE.
- [5] PRIO.
- [6] ABORT: write-1 pulse, reads 0.
- Other bits read 0.
REQ-022 States: IDLE, RD, CAP, WR. BUSY=1 in every state except IDLE.
REQ-023 IDLE, START=1: if CNT!=0, go to RD; if CNT=0, set DONE and stay in IDLE. A START written while BUSY=1 is ignored.
REQ-024 RD: dma_en=1, dma_we=00, dma_addr=SRC[15:1]; hold all three until dma_ready=1.
REQ-025 RD accept with dma_resp=1: set ERR, go to IDLE. Accept with dma_resp=0: go to CAP.
REQ-026 CAP: dma_en=0; latch dma_dout into the internal data register; go to WR.
REQ-027 WR: dma_en=1, dma_we=11, dma_addr=DST[15:1], dma_din=latched data; hold until dma_ready=1.
REQ-028 WR accept with dma_resp=1: set ERR, go to IDLE.
REQ-029 WR accept with dma_resp=0:
- SRC+=2, DST+=2, CNT-=1; SRC and DST wrap modulo 2^16.
- If CNT was 1, set DONE and go to IDLE; otherwise go to RD.
REQ-030 Each word costs at least 3 cycles (RD, CAP, WR) with zero-wait dma_ready.
REQ-031 ABORT sets a pending flag; an access already on the bus is never withdrawn.
REQ-032 A pending abort takes effect at the next RD accept, CAP or WR accept: go to IDLE, DONE unchanged, flag cleared. On a WR accept the SRC/DST/CNT updates still occur.
REQ-033 ABORT in IDLE has no effect. START and ABORT in the same write: no transfer starts.
REQ-034 If hardware sets DONE/ERR in the same cycle as a software clear, the set wins.
REQ-035 dma_en, dma_we, dma_addr and dma_din are 0 in IDLE and CAP.

Reset
REQ-036 Asserting puc_rst at any time, including mid-transfer, forces the FSM to IDLE, clears all registers and the abort flag, and drives every output to 0.

Configuration
REQ-037 Macro DMA_IRQ_EN defined: irq_dma = IE & (DONE | ERR), combinational from registers.
REQ-038 Macro DMA_IRQ_EN undefined: irq_dma tied 0; IE is not implemented and reads 0.

Verification
REQ-039 SRC=0x0200, DST=0x0300, CNT=3, START, zero-wait ready: three read/write pairs to word addresses 0x100/0x180, 0x101/0x181, 0x102/0x182; data copied; final SRC=0x0206, DST=0x0306, CNT=0, DONE=1, BUSY=0.
REQ-040 CNT=0, START: no dma_en pulse; DONE=1 on the next cycle.
REQ-041 dma_ready held low for 5 cycles in RD: dma_en and dma_addr stay stable for all 5 cycles; transfer completes correctly after ready.
REQ-042 dma_resp=1 on the second WR accept: ERR=1, CNT=CNT_initial-1, FSM returns to IDLE; with DMA_IRQ_EN and IE=1, irq_dma=1 until ERR is cleared by writing 0x0008.
REQ-043 ABORT while WR is stalled: write completes, FSM reaches IDLE, DONE=0; SRC=0xFFFE with CNT=2 shows SRC wrapping to 0x0000.
REQ-044 puc_rst asserted during CAP: all outputs 0 asynchronously; after release, registers read 0.

Source files
------------

// File: rtl/simple_dma_master_if.sv
// -----------------------------------------------------------------------------
// simple_dma_master_if
// Bundles the peripheral register bus and the DMA master bus of
// simple_dma_master.
//   per_addr/per_din/per_en/per_we : peripheral access to the DMA registers
//   per_dout                        : register read data (0 when not selected)
//   dma_addr/dma_din/dma_en/dma_we  : DMA access request (word address)
//   dma_priority                    : DMA priority request
//   dma_dout/dma_ready/dma_resp     : DMA read data, accept and error response
//   irq_dma                         : interrupt request
// Modports: master = DMA block side, slave = system/memory side.
// -----------------------------------------------------------------------------
interface simple_dma_master_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_priority;
    logic [15:0] dma_dout;
    logic        dma_ready;
    logic        dma_resp;

    logic        irq_dma;

    modport master (
        input  per_addr, per_din, per_en, per_we,
        input  dma_dout, dma_ready, dma_resp,
        output per_dout,
        output dma_addr, dma_din, dma_en, dma_we, dma_priority,
        output irq_dma
    );

    modport slave (
        output per_addr, per_din, per_en, per_we,
        output dma_dout, dma_ready, dma_resp,
        input  per_dout,
        input  dma_addr, dma_din, dma_en, dma_we, dma_priority,
        input  irq_dma
    );
endinterface

// File: rtl/simple_dma_master.sv
// -----------------------------------------------------------------------------
// simple_dma_master
// Memory-to-memory word copy engine with a 4-register peripheral interface:
// offset 0x0 SRC, 0x2 DST, 0x4 CNT, 0x6 CTRL
// (CTRL: [0]START [1]BUSY [2]DONE [3]ERR [4]IE [5]PRIO [6]ABORT).
// Each word is moved as RD (read request) -> CAP (capture data) -> WR.
// Ports:
//   mclk    : main clock, rising edge
//   puc_rst : asynchronous active-high reset
//   bus     : simple_dma_master_if.master (peripheral + DMA bus + irq)
// Optional feature: define DMA_IRQ_EN to implement CTRL.IE and drive irq_dma;
// otherwise IE reads 0 and irq_dma is tied 0.
// -----------------------------------------------------------------------------
module simple_dma_master #(
    parameter logic [14:0] BASE_ADDR = 15'h0110,
    parameter int unsigned DEC_WD    = 3
) (
    input  logic                       mclk,
    input  logic                       puc_rst,
    simple_dma_master_if.master        bus
);

    localparam int unsigned IDX_WD = DEC_WD - 1;
    localparam logic [IDX_WD-1:0] IDX_SRC  = IDX_WD'(0);
    localparam logic [IDX_WD-1:0] IDX_DST  = IDX_WD'(1);
    localparam logic [IDX_WD-1:0] IDX_CNT  = IDX_WD'(2);
    localparam logic [IDX_WD-1:0] IDX_CTRL = IDX_WD'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] src_q, dst_q, cnt_q, data_q;
    logic        done_q, err_q, prio_q, abort_q, ie_q;
    logic        busy;

    // ---------------- register decode ----------------
    // per_addr is a word address; per_addr[DEC_WD-2:0] selects the register.
    logic              reg_sel;
    logic [IDX_WD-1:0] reg_idx;
    logic              reg_wr, reg_rd;
    logic              wr_src, wr_dst, wr_cnt, wr_ctrl;
    logic              start_req, abort_req;

    assign reg_sel = bus.per_en && (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_idx = bus.per_addr[DEC_WD-2:0];
    assign reg_wr  = reg_sel && (bus.per_we != 2'b00);
    assign reg_rd  = reg_sel && (bus.per_we == 2'b00);

    assign wr_src  = reg_wr && (reg_idx == IDX_SRC);
    assign wr_dst  = reg_wr && (reg_idx == IDX_DST);
    assign wr_cnt  = reg_wr && (reg_idx == IDX_CNT);
    assign wr_ctrl = reg_wr && (reg_idx == IDX_CTRL);

    assign start_req = wr_ctrl && bus.per_din[0];
    assign abort_req = wr_ctrl && bus.per_din[6];

    assign busy = (state_q != S_IDLE);

    // ---------------- FSM ----------------
    logic set_done, set_err, advance, latch;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        set_done = 1'b0;
        set_err  = 1'b0;
        advance  = 1'b0;
        latch    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // START together with ABORT starts nothing
                if (start_req && !abort_req) begin
                    if (cnt_q != 16'd0) state_d  = S_RD;
                    else                set_done = 1'b1;
                end
            end
            S_RD: begin
                if (bus.dma_ready) begin
                    if (bus.dma_resp) begin
                        set_err = 1'b1;
                        state_d = S_IDLE;
                    end else if (abort_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CAP;
                    end
                end
            end
            S_CAP: begin
                latch   = 1'b1;
                state_d = abort_q ? S_IDLE : S_WR;
            end
            S_WR: begin
                if (bus.dma_ready) begin
                    if (bus.dma_resp) begin
                        set_err = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // address/count update happens even when aborting
                        advance = 1'b1;
                        if (abort_q) begin
                            state_d = S_IDLE;
                        end else if (cnt_q == 16'd1) begin
                            set_done = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            if (wr_src && !busy)  src_q <= {bus.per_din[15:1], 1'b0};
            else if (advance)     src_q <= src_q + 16'd2;

            if (wr_dst && !busy)  dst_q <= {bus.per_din[15:1], 1'b0};
            else if (advance)     dst_q <= dst_q + 16'd2;

            if (wr_cnt && !busy)  cnt_q <= bus.per_din;
            else if (advance)     cnt_q <= cnt_q - 16'd1;

            if (latch)            data_q <= bus.dma_dout;
        end
    end

    // Hardware set of DONE/ERR takes priority over a software clear.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            prio_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            if (set_done)                          done_q <= 1'b1;
            else if (wr_ctrl && bus.per_din[2])    done_q <= 1'b0;

            if (set_err)                           err_q <= 1'b1;
            else if (wr_ctrl && bus.per_din[3])    err_q <= 1'b0;

            if (wr_ctrl)                           prio_q <= bus.per_din[5];

            // pending abort only exists while busy; dropped on any return to IDLE
            if (state_d == S_IDLE)                 abort_q <= 1'b0;
            else if (abort_req && busy)            abort_q <= 1'b1;
        end
    end

`ifdef DMA_IRQ_EN
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst)      ie_q <= 1'b0;
        else if (wr_ctrl) ie_q <= bus.per_din[4];
    end
    assign bus.irq_dma = ie_q & (done_q | err_q);
`else
    assign ie_q        = 1'b0;
    assign bus.irq_dma = 1'b0;
`endif

    // ---------------- read-back ----------------
    logic [15:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            IDX_SRC:  rd_data = src_q;
            IDX_DST:  rd_data = dst_q;
            IDX_CNT:  rd_data = cnt_q;
            IDX_CTRL: rd_data = {9'd0, 1'b0, prio_q, ie_q, err_q, done_q, busy, 1'b0};
            default:  rd_data = '0;
        endcase
    end

    assign bus.per_dout = reg_rd ? rd_data : '0;

    // ---------------- DMA bus ----------------
    always_comb begin
        bus.dma_en   = 1'b0;
        bus.dma_we   = 2'b00;
        bus.dma_addr = '0;
        bus.dma_din  = '0;
        case (state_q)
            S_RD: begin
                bus.dma_en   = 1'b1;
                bus.dma_addr = src_q[15:1];
            end
            S_WR: begin
                bus.dma_en   = 1'b1;
                bus.dma_we   = 2'b11;
                bus.dma_addr = dst_q[15:1];
                bus.dma_din  = data_q;
            end
            default: ;
        endcase
    end

    assign bus.dma_priority = prio_q;

endmodule

// File: tb/tb_simple_dma_master.sv
module tb_simple_dma_master;

    localparam logic [13:0] PER_BASE = 14'h0088;

    typedef struct packed {
        logic [1:0]  we;
        logic [14:0] addr;
        logic [15:0] din;
    } acc_t;

    logic mclk;
    logic puc_rst;
    simple_dma_master_if bus_if();

    simple_dma_master #(.BASE_ADDR(15'h0110), .DEC_WD(3)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus_if)
    );

    int total = 0;
    int bad   = 0;

    acc_t exp_q[$];
    acc_t obs_q[$];
    logic [15:0] mem [int];
    int   wr_count = 0;
    int   en_seen  = 0;
    int   err_at   = -1;
    logic rdy;
    logic stall_wr;

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    assign bus_if.dma_ready = rdy && !(stall_wr && bus_if.dma_we == 2'b11);
    assign bus_if.dma_resp  = bus_if.dma_en && (bus_if.dma_we == 2'b11) && (wr_count == err_at);

    // memory-side responder and access monitor
    always @(posedge mclk) begin
        if (bus_if.dma_en) en_seen <= en_seen + 1;
        if (bus_if.dma_en && bus_if.dma_ready) begin
            obs_q.push_back('{we: bus_if.dma_we, addr: bus_if.dma_addr, din: bus_if.dma_din});
            if (bus_if.dma_we == 2'b00) begin
                bus_if.dma_dout <= mem.exists(int'(bus_if.dma_addr)) ? mem[int'(bus_if.dma_addr)] : 16'h0000;
            end else begin
                if (!bus_if.dma_resp) mem[int'(bus_if.dma_addr)] = bus_if.dma_din;
                wr_count <= wr_count + 1;
            end
        end
    end

    task automatic per_write(input logic [1:0] idx, input logic [15:0] d);
        @(negedge mclk);
        bus_if.per_addr = PER_BASE + 14'(idx);
        bus_if.per_din  = d;
        bus_if.per_we   = 2'b11;
        bus_if.per_en   = 1'b1;
        @(negedge mclk);
        bus_if.per_en   = 1'b0;
        bus_if.per_we   = 2'b00;
    endtask

    task automatic per_read(input logic [1:0] idx, output logic [15:0] v);
        bus_if.per_addr = PER_BASE + 14'(idx);
        bus_if.per_we   = 2'b00;
        bus_if.per_en   = 1'b1;
        #1 v = bus_if.per_dout;
        bus_if.per_en   = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        logic [15:0] v;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge mclk);
            per_read(2'd3, v);
            if (!v[1]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        puc_rst = 1'b1;
        repeat (3) @(negedge mclk);
        total++;
        if ({bus_if.dma_en, bus_if.dma_we, bus_if.dma_addr, bus_if.dma_din, bus_if.dma_priority, bus_if.irq_dma} !== '0) begin
            bad++; $display("FAIL reset_outputs got en=%b we=%b addr=%h din=%h prio=%b irq=%b want all 0",
                bus_if.dma_en, bus_if.dma_we, bus_if.dma_addr, bus_if.dma_din, bus_if.dma_priority, bus_if.irq_dma);
        end
        puc_rst = 1'b0;
        @(negedge mclk);
        for (int r = 0; r < 4; r++) begin
            per_read(2'(r), v);
            total++;
            if (v !== 16'h0000) begin bad++; $display("FAIL reset_reg%0d got %h want 0000", r, v); end
        end
        per_write(2'd0, 16'h1235);
        per_read(2'd0, v);
        total++;
        if (v !== 16'h1234) begin bad++; $display("FAIL src_bit0 got %h want 1234", v); end
        per_write(2'd1, 16'h2001);
        per_read(2'd1, v);
        total++;
        if (v !== 16'h2000) begin bad++; $display("FAIL dst_bit0 got %h want 2000", v); end
        bus_if.per_addr = 14'h0100; bus_if.per_we = 2'b00; bus_if.per_en = 1'b1;
        #1 v = bus_if.per_dout;
        bus_if.per_en = 1'b0;
        total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL unselected_read got %h want 0000", v); end
    endtask

    task automatic test_copy();
        logic [15:0] v;
        logic ok;
        logic [15:0] data [3] = '{16'hA5C3, 16'h5A3C, 16'h0F0F};
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < 3; i++) begin
            mem[32'h100 + i] = data[i];
            mem[32'h180 + i] = 16'h0000;
            exp_q.push_back('{we: 2'b00, addr: 15'(16'h100 + i), din: 16'h0});
            exp_q.push_back('{we: 2'b11, addr: 15'(16'h180 + i), din: data[i]});
        end
        per_write(2'd0, 16'h0200);
        per_write(2'd1, 16'h0300);
        per_write(2'd2, 16'd3);
        per_write(2'd3, 16'h0021);
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL copy_timeout busy=1 want busy=0"); end
        total++;
        if (obs_q.size() != 6) begin bad++; $display("FAIL copy_count got %0d want 6", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            acc_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we == 2'b11 && o.din !== e.din)) begin
                bad++; $display("FAIL copy_access got we=%b addr=%h din=%h want we=%b addr=%h din=%h",
                    o.we, o.addr, o.din, e.we, e.addr, e.din);
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem[32'h180 + i] !== data[i]) begin bad++; $display("FAIL copy_mem%0d got %h want %h", i, mem[32'h180 + i], data[i]); end
        end
        per_read(2'd0, v); total++;
        if (v !== 16'h0206) begin bad++; $display("FAIL copy_src got %h want 0206", v); end
        per_read(2'd1, v); total++;
        if (v !== 16'h0306) begin bad++; $display("FAIL copy_dst got %h want 0306", v); end
        per_read(2'd2, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL copy_cnt got %h want 0000", v); end
        per_read(2'd3, v); total++;
        if (v !== 16'h0024) begin bad++; $display("FAIL copy_ctrl got %h want 0024", v); end
        total++;
        if (bus_if.dma_priority !== 1'b1) begin bad++; $display("FAIL copy_prio got %b want 1", bus_if.dma_priority); end
    endtask

    task automatic test_zero_count();
        logic [15:0] v;
        int base;
        per_write(2'd3, 16'h000C);
        per_write(2'd2, 16'd0);
        base = en_seen;
        per_write(2'd3, 16'h0001);
        per_read(2'd3, v);
        total++;
        if (v !== 16'h0004) begin bad++; $display("FAIL zero_ctrl got %h want 0004", v); end
        repeat (4) @(negedge mclk);
        total++;
        if (en_seen != base) begin bad++; $display("FAIL zero_no_access got %0d dma_en cycles want 0", en_seen - base); end
    endtask

    task automatic test_stall();
        logic [15:0] v;
        logic ok;
        exp_q.delete(); obs_q.delete();
        mem[32'h300] = 16'hC0DE;
        exp_q.push_back('{we: 2'b00, addr: 15'h0300, din: 16'h0});
        exp_q.push_back('{we: 2'b11, addr: 15'h0380, din: 16'hC0DE});
        per_write(2'd3, 16'h000C);
        per_write(2'd0, 16'h0600);
        per_write(2'd1, 16'h0700);
        per_write(2'd2, 16'd1);
        rdy = 1'b0;
        per_write(2'd3, 16'h0001);
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus_if.dma_en !== 1'b1 || bus_if.dma_we !== 2'b00 || bus_if.dma_addr !== 15'h0300) begin
                bad++; $display("FAIL stall_hold cyc%0d got en=%b we=%b addr=%h want en=1 we=00 addr=0300",
                    c, bus_if.dma_en, bus_if.dma_we, bus_if.dma_addr);
            end
            @(negedge mclk);
        end
        per_write(2'd0, 16'hAAAA);
        per_write(2'd2, 16'h0055);
        rdy = 1'b1;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_timeout busy=1 want busy=0"); end
        total++;
        if (obs_q.size() != 2) begin bad++; $display("FAIL stall_count got %0d want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            acc_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we == 2'b11 && o.din !== e.din)) begin
                bad++; $display("FAIL stall_access got we=%b addr=%h din=%h want we=%b addr=%h din=%h",
                    o.we, o.addr, o.din, e.we, e.addr, e.din);
            end
        end
        per_read(2'd0, v); total++;
        if (v !== 16'h0602) begin bad++; $display("FAIL stall_src got %h want 0602", v); end
        per_read(2'd2, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL stall_cnt got %h want 0000", v); end
        per_read(2'd3, v); total++;
        if (v !== 16'h0004) begin bad++; $display("FAIL stall_ctrl got %h want 0004", v); end
    endtask

    task automatic test_error();
        logic [15:0] v;
        logic ok;
        logic [15:0] want_ctrl;
        logic want_irq;
        exp_q.delete(); obs_q.delete();
        mem[32'h200] = 16'h1111;
        mem[32'h201] = 16'h2222;
        exp_q.push_back('{we: 2'b00, addr: 15'h0200, din: 16'h0});
        exp_q.push_back('{we: 2'b11, addr: 15'h0280, din: 16'h1111});
        exp_q.push_back('{we: 2'b00, addr: 15'h0201, din: 16'h0});
        exp_q.push_back('{we: 2'b11, addr: 15'h0281, din: 16'h2222});
`ifdef DMA_IRQ_EN
        want_ctrl = 16'h0018; want_irq = 1'b1;
`else
        want_ctrl = 16'h0008; want_irq = 1'b0;
`endif
        per_write(2'd3, 16'h000C);
        per_write(2'd0, 16'h0400);
        per_write(2'd1, 16'h0500);
        per_write(2'd2, 16'd4);
        err_at = wr_count + 1;
        per_write(2'd3, 16'h0011);
        wait_idle(ok);
        err_at = -1;
        total++;
        if (!ok) begin bad++; $display("FAIL err_timeout busy=1 want busy=0"); end
        total++;
        if (obs_q.size() != 4) begin bad++; $display("FAIL err_count got %0d want 4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            acc_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we == 2'b11 && o.din !== e.din)) begin
                bad++; $display("FAIL err_access got we=%b addr=%h din=%h want we=%b addr=%h din=%h",
                    o.we, o.addr, o.din, e.we, e.addr, e.din);
            end
        end
        per_read(2'd2, v); total++;
        if (v !== 16'd3) begin bad++; $display("FAIL err_cnt got %h want 0003", v); end
        per_read(2'd0, v); total++;
        if (v !== 16'h0402) begin bad++; $display("FAIL err_src got %h want 0402", v); end
        per_read(2'd3, v); total++;
        if (v !== want_ctrl) begin bad++; $display("FAIL err_ctrl got %h want %h", v, want_ctrl); end
        repeat (2) @(negedge mclk);
        total++;
        if (bus_if.irq_dma !== want_irq) begin bad++; $display("FAIL err_irq got %b want %b", bus_if.irq_dma, want_irq); end
        per_write(2'd3, 16'h0008);
        per_read(2'd3, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL err_clear got %h want 0000", v); end
        total++;
        if (bus_if.irq_dma !== 1'b0) begin bad++; $display("FAIL err_irq_clear got %b want 0", bus_if.irq_dma); end
    endtask

    task automatic test_abort_wrap();
        logic [15:0] v;
        logic ok;
        logic seen;
        exp_q.delete(); obs_q.delete();
        mem[32'h7FFF] = 16'hBEEF;
        exp_q.push_back('{we: 2'b00, addr: 15'h7FFF, din: 16'h0});
        exp_q.push_back('{we: 2'b11, addr: 15'h0400, din: 16'hBEEF});
        per_write(2'd3, 16'h000C);
        per_write(2'd0, 16'hFFFE);
        per_write(2'd1, 16'h0800);
        per_write(2'd2, 16'd2);
        stall_wr = 1'b1;
        per_write(2'd3, 16'h0001);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus_if.dma_we == 2'b11) begin seen = 1'b1; break; end
            @(negedge mclk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL abort_reach_wr got no write request want write request"); end
        per_write(2'd3, 16'h0040);
        @(negedge mclk);
        stall_wr = 1'b0;
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL abort_timeout busy=1 want busy=0"); end
        total++;
        if (obs_q.size() != 2) begin bad++; $display("FAIL abort_count got %0d want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            acc_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we == 2'b11 && o.din !== e.din)) begin
                bad++; $display("FAIL abort_access got we=%b addr=%h din=%h want we=%b addr=%h din=%h",
                    o.we, o.addr, o.din, e.we, e.addr, e.din);
            end
        end
        per_read(2'd0, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL abort_src_wrap got %h want 0000", v); end
        per_read(2'd1, v); total++;
        if (v !== 16'h0802) begin bad++; $display("FAIL abort_dst got %h want 0802", v); end
        per_read(2'd2, v); total++;
        if (v !== 16'd1) begin bad++; $display("FAIL abort_cnt got %h want 0001", v); end
        per_read(2'd3, v); total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL abort_ctrl got %h want 0000", v); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        per_write(2'd3, 16'h000C);
        per_write(2'd0, 16'h0900);
        per_write(2'd1, 16'h0A00);
        per_write(2'd2, 16'd2);
        per_write(2'd3, 16'h0021);
        @(negedge mclk);
        total++;
        if (bus_if.dma_en !== 1'b0 || bus_if.dma_priority !== 1'b1) begin
            bad++; $display("FAIL rstmid_cap got en=%b prio=%b want en=0 prio=1", bus_if.dma_en, bus_if.dma_priority);
        end
        puc_rst = 1'b1;
        #1;
        total++;
        if ({bus_if.dma_en, bus_if.dma_we, bus_if.dma_addr, bus_if.dma_din, bus_if.dma_priority, bus_if.irq_dma, bus_if.per_dout} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got en=%b we=%b addr=%h din=%h prio=%b irq=%b dout=%h want all 0",
                bus_if.dma_en, bus_if.dma_we, bus_if.dma_addr, bus_if.dma_din, bus_if.dma_priority, bus_if.irq_dma, bus_if.per_dout);
        end
        @(negedge mclk);
        puc_rst = 1'b0;
        repeat (2) @(negedge mclk);
        for (int r = 0; r < 4; r++) begin
            per_read(2'(r), v);
            total++;
            if (v !== 16'h0000) begin bad++; $display("FAIL rstmid_reg%0d got %h want 0000", r, v); end
        end
        total++;
        if (bus_if.dma_en !== 1'b0) begin bad++; $display("FAIL rstmid_idle got en=%b want 0", bus_if.dma_en); end
    endtask

    initial begin
        puc_rst = 1'b1;
        rdy = 1'b1;
        stall_wr = 1'b0;
        bus_if.per_addr = '0;
        bus_if.per_din  = '0;
        bus_if.per_en   = 1'b0;
        bus_if.per_we   = 2'b00;
        test_reset();
        test_copy();
        test_zero_count();
        test_stall();
        test_error();
        test_abort_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
